// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready/last byte stream in preamble,
// SFD, zero pad and Ethernet FCS, then enforces the inter-frame gap.
// The GMII outputs are registered: each cycle the output logic computes
// the byte for the next cycle from the current state and inputs.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       frame_done,
  output logic       underrun_err
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG, DROP
  } state_t;

  localparam logic [15:0] PRE_L = 16'(PREAMBLE_LEN);
  localparam logic [15:0] IFG_L = 16'(IFG_BYTES);
  localparam logic [11:0] MIN_P = 12'(MIN_PAYLOAD);

  state_t      state, state_nxt;
  logic [15:0] aux_cnt;
  logic [10:0] byte_cnt, cnt_inc;
  logic [31:0] crc, crc_step, fcs;
  logic        pre_last, fcs_last, ifg_last, short_frame;

  logic        tx_en_d, frame_done_d, underrun_d, crc_upd;
  logic [7:0]  txd_d, crc_byte;

  // Reflected CRC-32 (0xEDB88320) advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Byte count saturates at 2047; oversize frames still go out in full.
  assign cnt_inc     = (byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1;
  assign short_frame = ({1'b0, cnt_inc} < MIN_P);
  assign pre_last    = (aux_cnt == PRE_L);
  assign fcs_last    = (aux_cnt[1:0] == 2'd3);
  assign ifg_last    = (aux_cnt == IFG_L);
  assign fcs         = ~crc;
  assign crc_step    = crc32_byte(crc, crc_byte);

  // Ready is a pure state decode so it never depends on s_tvalid.
  assign s_tready = (state == SFD) || (state == DATA) || (state == DROP);

  // State register plus the shared per-state cycle counter; entering
  // PREAMBLE starts at 1 because the first 0x55 is emitted on that edge.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      aux_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        aux_cnt <= (state_nxt == PREAMBLE) ? 16'd1 : '0;
      else
        aux_cnt <= aux_cnt + 16'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (s_tvalid) state_nxt = (PREAMBLE_LEN == 0) ? SFD : PREAMBLE;
      PREAMBLE: if (pre_last) state_nxt = SFD;
      SFD, DATA: begin
        if (!s_tvalid)    state_nxt = DROP;
        else if (s_tlast) state_nxt = short_frame ? PAD : FCS;
        else              state_nxt = DATA;
      end
      PAD:      if (!short_frame) state_nxt = FCS;
      FCS:      if (fcs_last) state_nxt = IFG;
      IFG:      if (ifg_last) state_nxt = IDLE;
      DROP:     if (s_tvalid && s_tlast) state_nxt = IFG;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode: value each GMII output takes on the coming edge, and
  // which byte (payload or pad) feeds the CRC on that edge.
  always_comb begin
    tx_en_d      = 1'b0;
    txd_d        = 8'h00;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    crc_upd      = 1'b0;
    crc_byte     = 8'h00;
    case (state)
      IDLE: begin
        if (s_tvalid) begin
          tx_en_d = 1'b1;
          txd_d   = (PREAMBLE_LEN == 0) ? 8'hD5 : 8'h55;
        end
      end
      PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = pre_last ? 8'hD5 : 8'h55;
      end
      SFD, DATA: begin
        if (s_tvalid) begin
          tx_en_d  = 1'b1;
          txd_d    = s_tdata;
          crc_upd  = 1'b1;
          crc_byte = s_tdata;
        end else begin
          underrun_d = 1'b1;
        end
      end
      PAD: begin
        tx_en_d = 1'b1;
        crc_upd = 1'b1;
      end
      FCS: begin
        tx_en_d      = 1'b1;
        frame_done_d = fcs_last;
        case (aux_cnt[1:0])
          2'd0:    txd_d = fcs[7:0];
          2'd1:    txd_d = fcs[15:8];
          2'd2:    txd_d = fcs[23:16];
          default: txd_d = fcs[31:24];
        endcase
      end
      default: ;
    endcase
  end

  // Registered GMII outputs, CRC and payload byte counter.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_tx_en   <= 1'b0;
      gmii_txd     <= 8'h00;
      frame_done   <= 1'b0;
      underrun_err <= 1'b0;
      crc          <= '1;
      byte_cnt     <= '0;
    end else begin
      gmii_tx_en   <= tx_en_d;
      gmii_txd     <= txd_d;
      frame_done   <= frame_done_d;
      underrun_err <= underrun_d;
      if (state == IDLE) begin
        crc      <= '1;
        byte_cnt <= '0;
      end else if (crc_upd) begin
        crc      <= crc_step;
        byte_cnt <= cnt_inc;
      end
    end
  end

endmodule
